// File: rtl/data_bram_stream_reader.sv
// ----------------------------------------------------------------------------
// data_bram_stream_reader
//
// Sweeps the data BRAM read port over [base_addr, base_addr+len-1] and turns
// the 1-cycle-latency reads into a valid/ready stream for the LSTM datapath.
// A 4-entry output FIFO absorbs read latency and downstream backpressure.
// Reads are only issued while buffered + in-flight words leave room in it.
//
// Optional feature: define DBR_PERF_CNT_EN to add the stall_cnt output.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, base_addr, len  pass request (sampled in IDLE only)
//   abort                  synchronous flush back to IDLE, no done pulse
//   rd_addr, re            registered BRAM read address / enable
//   bram_dout              BRAM read data, valid the cycle after re
//   m_data, m_valid,
//   m_ready, m_last        output stream
//   busy, done, cfg_err    pass status / done pulse / rejected-start pulse
//   stall_cnt              (DBR_PERF_CNT_EN) m_valid && !m_ready cycles
// ----------------------------------------------------------------------------
module data_bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 96
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
`ifdef DBR_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int CW = ADDR_WIDTH + 2;  // range-check width, cannot overflow
    localparam int LW = ADDR_WIDTH + 1;  // word-count width

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         issued_q, issued_d;
    logic [LW-1:0]         beats_q, beats_d;
    logic                  re_q, re_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  cap_q, cap_d;       // bram_dout holds a wanted word this cycle
    logic                  cfg_err_q, cfg_err_d;

    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            occ_q;

    logic       cfg_ok, room, beat, push, pop, start_acc;
    logic [1:0] inflight;

    assign cfg_ok   = (len != '0) &&
                      (({2'b00, base_addr} + {1'b0, len}) <= CW'(MEM_SIZE));
    // Reads issued but not yet in the FIFO: one waiting on the BRAM, one on its output.
    assign inflight = {1'b0, re_q} + {1'b0, cap_q};
    assign room     = ({1'b0, occ_q} + {2'b00, inflight}) < 4'd4;
    assign beat     = m_valid && m_ready;
    // abort discards buffer contents and any late BRAM data.
    assign push     = cap_q && !abort;
    assign pop      = beat && !abort;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        issued_d  = issued_q;
        beats_d   = beats_q;
        re_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        cap_d     = re_q;
        cfg_err_d = 1'b0;
        start_acc = 1'b0;

        if (beat) beats_d = beats_q + LW'(1);

        if (abort) begin
            state_d  = S_IDLE;
            cap_d    = 1'b0;
            beats_d  = '0;
            issued_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            start_acc = 1'b1;
                            base_d    = base_addr;
                            len_d     = len;
                            beats_d   = '0;
                            issued_d  = LW'(1);
                            re_d      = 1'b1;
                            rd_addr_d = base_addr;
                            state_d   = (len == LW'(1)) ? S_DRAIN : S_READ;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (room) begin
                        re_d      = 1'b1;
                        rd_addr_d = base_q + issued_q[ADDR_WIDTH-1:0];
                        issued_d  = issued_q + LW'(1);
                        if (issued_q + LW'(1) == len_q) state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (m_last && m_ready) state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            beats_q   <= '0;
            re_q      <= 1'b0;
            rd_addr_q <= '0;
            cap_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            beats_q   <= beats_d;
            re_q      <= re_d;
            rd_addr_q <= rd_addr_d;
            cap_q     <= cap_d;
            cfg_err_q <= cfg_err_d;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
                occ_q <= occ_q + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    // NOTE: the FIFO storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bram_dout;
    end

    assign rd_addr = rd_addr_q;
    assign re      = re_q;
    assign m_valid = (occ_q != '0);
    // Gated so the stream data reads 0 while empty, including straight out of reset.
    assign m_data  = m_valid ? fifo_mem[rd_ptr_q] : '0;
    assign m_last  = m_valid && (beats_q == len_q - LW'(1));
    assign busy    = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign cfg_err = cfg_err_q;

`ifdef DBR_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_bram_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_data_bram_stream_reader
//
// Directed scenarios against a behavioural BRAM. Stimulus pushes the expected
// beats of each pass into a queue; an independent negedge monitor pops and
// compares on every accepted beat and also watches stall stability, read
// address range, outstanding reads and done timing.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_bram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int MS = 96;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] rd_addr;
    logic          re;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, busy, done, cfg_err;
`ifdef DBR_PERF_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    data_bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .re        (re),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
`ifdef DBR_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural BRAM with a registered read port.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) if (re) bram_dout <= mem[rd_addr];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW:0]   exp_q [$];          // {last, data}
    int            pass_beats = 0;
    int            first_beat_cyc = 0;
    int            last_beat_cyc = -10;
    int            rd_cnt = 0;
    int            bt_cnt = 0;
    logic [AW-1:0] last_rd_addr = '0;
    int            ready_mode = 0;     // 0: always ready, 1: 1,0,0 pattern, other: manual
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      m_ready = 1'b1;
        else if (ready_mode == 1) m_ready = (cyc % 3 == 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid_held", {63'd0, m_valid}, 64'd1);
                check("stall_data_held", {32'd0, m_data}, {32'd0, prev_data});
            end
            if (re) begin
                rd_cnt++;
                last_rd_addr = rd_addr;
                check("rd_addr_in_range", {63'd0, int'(rd_addr) <= MS - 1}, 64'd1);
                check("outstanding_le_4", {63'd0, (rd_cnt - bt_cnt) <= 4}, 64'd1);
            end
            if (m_valid && m_ready && !abort) begin
                bt_cnt++;
                if (pass_beats == 0) first_beat_cyc = cyc;
                pass_beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {32'd0, m_data}, 64'hDEAD);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("beat_data", {32'd0, m_data}, {32'd0, e[DW-1:0]});
                    check("beat_last", {63'd0, m_last}, {63'd0, e[DW]});
                end
                if (m_last) last_beat_cyc = cyc;
            end
            if (done) begin
                check("done_cycle_after_last", 64'(cyc), 64'(last_beat_cyc + 1));
                check("busy_low_at_done", {63'd0, busy}, 64'd0);
            end
            prev_stall = m_valid && !m_ready && !abort;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_start(input int b, input int l, input bit expect_ok);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        if (expect_ok) begin
            pass_beats = 0;
            rd_cnt     = 0;
            bt_cnt     = 0;
            for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), mem[b + i]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("cfg_err_after_start", {63'd0, cfg_err}, {63'd0, !expect_ok});
        check("busy_after_start", {63'd0, busy}, {63'd0, expect_ok});
        check("re_after_start", {63'd0, re}, {63'd0, expect_ok});
        if (expect_ok) check("first_rd_addr", {57'd0, rd_addr}, 64'(b));
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic full_pass_check();
        ready_mode = 0;
        do_start(0, 96, 1);
        @(posedge clk); #1;
        check("latency_no_valid_k1", {63'd0, m_valid}, 64'd0);
        @(posedge clk); #1;
        check("latency_valid_k2", {63'd0, m_valid}, 64'd1);
        wait_done(300);
        check("throughput_96_cycles", 64'(last_beat_cyc - first_beat_cyc), 64'd95);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_re"}, {63'd0, re}, 64'd0);
        check({tag, "_rd_addr"}, {57'd0, rd_addr}, 64'd0);
        check({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_m_data"}, {32'd0, m_data}, 64'd0);
        check({tag, "_m_last"}, {63'd0, m_last}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_cfg_err"}, {63'd0, cfg_err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        bit reached;
        for (int i = 0; i < 2**AW; i++) mem[i] = 32'hDA7A_0000 + i * 32'h0001_0003;

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // 1: full sweep at full throughput.
        full_pass_check();

        // 2: short pass under 1,0,0 backpressure.
        ready_mode = 1;
        do_start(10, 5, 1);
        wait_done(200);

        // 3: configuration checks.
        ready_mode = 0;
        do_start(0, 0, 0);
        @(posedge clk); #1;
        check("cfg_err_one_cycle", {63'd0, cfg_err}, 64'd0);
        check("no_re_after_reject", {63'd0, re}, 64'd0);
        do_start(90, 7, 0);
        do_start(90, 6, 1);
        wait_done(100);
        check("last_rd_addr_95", {57'd0, last_rd_addr}, 64'd95);

        // 4: abort after three beats, then a short clean pass.
        ready_mode = 3;
        m_ready    = 1'b1;
        do_start(0, 20, 1);
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (pass_beats >= 3) begin
                reached = 1;
                break;
            end
        end
        check("abort_after_3_beats", {63'd0, reached}, 64'd1);
        #1;
        m_ready = 1'b0;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        rd_cnt = 0;
        bt_cnt = 0;
        check("abort_m_valid", {63'd0, m_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_re", {63'd0, re}, 64'd0);
        ready_mode = 0;
        seen_done  = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("no_done_after_abort", {63'd0, seen_done}, 64'd0);
        do_start(0, 2, 1);
        wait_done(50);

        // 5: reset mid-pass, then a full pass again.
        ready_mode = 0;
        do_start(0, 96, 1);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midpass_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        full_pass_check();

`ifdef DBR_PERF_CNT_EN
        // 6: stall counter over a 7-cycle hold.
        ready_mode = 3;
        m_ready    = 1'b0;
        do_start(0, 4, 1);
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) begin
                reached = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("perf_valid_seen", {63'd0, reached}, 64'd1);
        repeat (7) @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_done(50);
        check("stall_cnt_7", {48'd0, stall_cnt}, 64'd7);
        ready_mode = 0;
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
